// File: rtl/serializer.sv
// Squeeze-side serializer: 256-bit permutation words out as bytes, LSB byte first, truncated to out_len.
// Optional SERIALIZER_DOUBLE_BUFFER_EN adds a holding register so word changes cost no bubble cycle.
module serializer #(
  parameter int unsigned IN_WIDTH  = 256,
  parameter int unsigned OUT_WIDTH = 8,
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 clear_n,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] out_len,
  input  logic [IN_WIDTH-1:0]  in_word,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] serial_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned PACKETS_IN_INPUT     = IN_WIDTH / OUT_WIDTH;
  localparam int unsigned PACKET_COUNTER_WIDTH = $clog2(PACKETS_IN_INPUT);
  localparam int unsigned LEN_EXT_WIDTH        = LEN_WIDTH + 1;
  localparam logic [PACKET_COUNTER_WIDTH-1:0] LAST_IDX =
    PACKET_COUNTER_WIDTH'(PACKETS_IN_INPUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_WORD = 2'd1,
    SHIFT     = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t                          state_q, state_d;
  logic [LEN_WIDTH-1:0]            bytes_left_q, bytes_left_d;
  logic [LEN_WIDTH-1:0]            words_left_q, words_left_d;
  logic [PACKET_COUNTER_WIDTH-1:0] idx_q, idx_d;
  logic [IN_WIDTH-1:0]             shift_q, shift_d;
`ifdef SERIALIZER_DOUBLE_BUFFER_EN
  logic [IN_WIDTH-1:0]             hold_q, hold_d;
  logic                            hold_full_q, hold_full_d;
`endif

  logic                 in_ready_d, out_valid_d, out_last_d, busy_d, done_d;
  logic [OUT_WIDTH-1:0] serial_out_d;

  logic                     accept_c;
  logic                     emit_c;
  logic [LEN_EXT_WIDTH-1:0] len_round_c;
  logic [LEN_WIDTH-1:0]     words_calc_c;

  assign accept_c = in_valid && in_ready;
  assign emit_c   = out_valid && out_ready;

  // ceil(out_len / packets-per-word) in one extra bit so the maximum length cannot wrap
  assign len_round_c  = LEN_EXT_WIDTH'(out_len) + LEN_EXT_WIDTH'(PACKETS_IN_INPUT - 1);
  assign words_calc_c = LEN_WIDTH'(len_round_c >> PACKET_COUNTER_WIDTH);

  // State and datapath registers
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q      <= IDLE;
      bytes_left_q <= '0;
      words_left_q <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
`ifdef SERIALIZER_DOUBLE_BUFFER_EN
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bytes_left_q <= bytes_left_d;
      words_left_q <= words_left_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
`ifdef SERIALIZER_DOUBLE_BUFFER_EN
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
`endif
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d      = state_q;
    bytes_left_d = bytes_left_q;
    words_left_d = words_left_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
`ifdef SERIALIZER_DOUBLE_BUFFER_EN
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          bytes_left_d = out_len;
          words_left_d = words_calc_c;
          state_d      = (out_len == '0) ? DONE : WAIT_WORD;
        end
      end
      WAIT_WORD: begin
        if (accept_c) begin
          shift_d      = in_word;
          idx_d        = '0;
          words_left_d = words_left_q - LEN_WIDTH'(1);
          state_d      = SHIFT;
        end
      end
      SHIFT: begin
`ifdef SERIALIZER_DOUBLE_BUFFER_EN
        if (accept_c) begin
          hold_d       = in_word;
          hold_full_d  = 1'b1;
          words_left_d = words_left_q - LEN_WIDTH'(1);
        end
`endif
        if (emit_c) begin
          shift_d      = shift_q >> OUT_WIDTH;
          bytes_left_d = bytes_left_q - LEN_WIDTH'(1);
          idx_d        = idx_q + PACKET_COUNTER_WIDTH'(1);
          if (bytes_left_q == LEN_WIDTH'(1)) begin
            state_d = DONE;
          end else if (idx_q == LAST_IDX) begin
`ifdef SERIALIZER_DOUBLE_BUFFER_EN
            // A word arriving on the wrap edge bypasses the empty holding register
            if (hold_full_q) begin
              shift_d     = hold_q;
              hold_full_d = 1'b0;
            end else if (accept_c) begin
              shift_d     = in_word;
              hold_full_d = 1'b0;
            end else begin
              state_d = WAIT_WORD;
            end
`else
            state_d = WAIT_WORD;
`endif
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state, registered below
  always_comb begin
    in_ready_d   = 1'b0;
    out_valid_d  = 1'b0;
    out_last_d   = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    serial_out_d = shift_d[OUT_WIDTH-1:0];
    out_valid_d  = (state_d == SHIFT);
    out_last_d   = (state_d == SHIFT) && (bytes_left_d == LEN_WIDTH'(1));
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == DONE);
    in_ready_d   = (state_d == WAIT_WORD) && (words_left_d != '0);
`ifdef SERIALIZER_DOUBLE_BUFFER_EN
    if ((state_d == SHIFT) && !hold_full_d && (words_left_d != '0)) begin
      in_ready_d = 1'b1;
    end
`endif
  end

  // Output registers
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      serial_out <= '0;
    end else begin
      in_ready   <= in_ready_d;
      out_valid  <= out_valid_d;
      out_last   <= out_last_d;
      busy       <= busy_d;
      done       <= done_d;
      serial_out <= serial_out_d;
    end
  end

endmodule

// File: tb/tb_serializer.sv
// Randomized bench for serializer: a byte-stream scoreboard built from the supplied words and out_len.
module tb_serializer;

  logic         clk;
  logic         clear_n;
  logic         start;
  logic [15:0]  out_len;
  logic [255:0] in_word;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   serial_out;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         busy;
  logic         done;

  serializer dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .start      (start),
    .out_len    (out_len),
    .in_word    (in_word),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .serial_out (serial_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [255:0] wbuf [8];

  // scoreboard state
  logic       mon_en = 1'b0;
  int         cur_len = 0;
  int         byte_ptr = 0;
  int         words_taken = 0;
  int         words_needed = 0;
  int         bubbles = 0;
  int         n_valid = 0;
  int         dut_done_cnt = 0;
  logic       seen_first = 1'b0;
  logic       sq_finished = 1'b0;
  logic       done_pend = 1'b0;
  logic       busy_m = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] first_byte = 8'h00;
  logic [7:0] last_byte = 8'h00;
  logic [7:0] eb;
  logic       nb, nd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare DUT outputs against the expected byte stream on every cycle
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall) check("stall_hold_valid", 64'(out_valid), 64'd1);
      if (out_valid) begin
        n_valid++;
        if (!seen_first) first_byte = serial_out;
        seen_first = 1'b1;
        last_byte = serial_out;
        if (byte_ptr < cur_len) begin
          eb = wbuf[byte_ptr / 32][8*(byte_ptr % 32) +: 8];
          check("byte", 64'(serial_out), 64'(eb));
          check("last", 64'(out_last), 64'(byte_ptr == cur_len - 1));
        end else begin
          check("extra_byte_valid", 64'(out_valid), 64'd0);
        end
      end else if (seen_first && byte_ptr < cur_len) begin
        bubbles++;
      end
      check("done", 64'(done), 64'(done_pend));
      check("busy", 64'(busy), 64'(busy_m));
      if (words_taken >= words_needed) check("in_ready_limit", 64'(in_ready), 64'd0);

      dut_done_cnt += int'(done);
      nb = busy_m;
      nd = 1'b0;
      if (done_pend) begin
        nb = 1'b0;
        sq_finished = 1'b1;
      end
      if (start && !busy_m) begin
        nb = 1'b1;
        if (cur_len == 0) nd = 1'b1;
      end
      if (in_valid && in_ready) words_taken++;
      if (out_valid && out_ready) begin
        byte_ptr++;
        if (byte_ptr == cur_len) nd = 1'b1;
      end
      prev_stall = out_valid && !out_ready;
      busy_m = nb;
      done_pend = nd;
    end
  end

  task automatic fill_pattern(input int base);
    for (int w = 0; w < 8; w++)
      for (int k = 0; k < 32; k++)
        wbuf[w][8*k +: 8] = 8'(base + w*32 + k);
  endtask

  task automatic fill_random();
    for (int w = 0; w < 8; w++)
      for (int k = 0; k < 8; k++)
        wbuf[w][32*k +: 32] = $urandom();
  endtask

  task automatic setup_model(input int len);
    cur_len = len;
    byte_ptr = 0;
    words_taken = 0;
    words_needed = (len + 31) / 32;
    bubbles = 0;
    n_valid = 0;
    dut_done_cnt = 0;
    seen_first = 1'b0;
    sq_finished = 1'b0;
    done_pend = 1'b0;
    busy_m = 1'b0;
    prev_stall = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic drive(input int rdy_mode, input int vld_mode);
    in_valid  = (vld_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    out_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
    in_word   = wbuf[(words_taken < 8) ? words_taken : 7];
  endtask

  task automatic issue_start(input int len);
    @(posedge clk); #1;
    start = 1'b1; out_len = 16'(len); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_squeeze(input int len, input int rdy_mode, input int vld_mode);
    int cyc;
    setup_model(len);
    issue_start(len);
    cyc = 0;
    while (!sq_finished && cyc < 3000) begin
      drive(rdy_mode, vld_mode);
      @(posedge clk); #1;
      cyc++;
    end
    check("squeeze_finished", 64'(sq_finished), 64'd1);
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_in_ready"},   64'(in_ready),   64'd0);
    check({tag, "_out_valid"},  64'(out_valid),  64'd0);
    check({tag, "_out_last"},   64'(out_last),   64'd0);
    check({tag, "_busy"},       64'(busy),       64'd0);
    check({tag, "_done"},       64'(done),       64'd0);
    check({tag, "_serial_out"}, 64'(serial_out), 64'd0);
  endtask

  initial begin
    int exp_bub;
    int len;
    int cyc;
    clear_n = 1'b0; start = 1'b0; out_len = '0; in_word = '0;
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    clear_n = 1'b1;
    setup_model(0);

    // single word, byte k = k
    fill_pattern(0);
    run_squeeze(32, 0, 0);
    check("single_first", 64'(first_byte), 64'h00);
    check("single_last", 64'(last_byte), 64'h1F);
    check("single_count", 64'(n_valid), 64'd32);
    check("single_done_cnt", 64'(dut_done_cnt), 64'd1);
    check("single_words", 64'(words_taken), 64'd1);

    // truncation into the second word
    fill_pattern(0);
    run_squeeze(40, 0, 1);
    check("trunc_words", 64'(words_taken), 64'd2);
    check("trunc_last", 64'(last_byte), 64'h27);
    check("trunc_done_cnt", 64'(dut_done_cnt), 64'd1);

    // zero length
    run_squeeze(0, 0, 0);
    check("zero_words", 64'(words_taken), 64'd0);
    check("zero_valid", 64'(n_valid), 64'd0);
    check("zero_done_cnt", 64'(dut_done_cnt), 64'd1);

    // single byte
    fill_random();
    wbuf[0][7:0] = 8'hA5;
    run_squeeze(1, 0, 0);
    check("one_byte", 64'(last_byte), 64'hA5);
    check("one_count", 64'(n_valid), 64'd1);
    check("one_done_cnt", 64'(dut_done_cnt), 64'd1);

    // word boundary gap with in_valid held high
    fill_random();
    run_squeeze(64, 0, 0);
`ifdef SERIALIZER_DOUBLE_BUFFER_EN
    exp_bub = 0;
`else
    exp_bub = 1;
`endif
    check("gap_bubbles", 64'(bubbles), 64'(exp_bub));
    check("gap_count", 64'(n_valid - bubbles), 64'(n_valid - exp_bub));
    check("gap_valid_cycles", 64'(n_valid), 64'd64);

    // same words under random backpressure
    run_squeeze(64, 1, 0);
    check("bp_words", 64'(words_taken), 64'd2);
    check("bp_done_cnt", 64'(dut_done_cnt), 64'd1);

    // randomized squeezes
    for (int i = 0; i < 8; i++) begin
      fill_random();
      len = $urandom_range(1, 130);
      run_squeeze(len, $urandom_range(0, 1), $urandom_range(0, 1));
      check("rand_words", 64'(words_taken), 64'((len + 31) / 32));
      check("rand_done_cnt", 64'(dut_done_cnt), 64'd1);
    end

    // asynchronous reset in the middle of a squeeze
    fill_pattern(8'h40);
    setup_model(64);
    issue_start(64);
    cyc = 0;
    while (byte_ptr < 10 && cyc < 200) begin
      drive(0, 0);
      @(posedge clk); #1;
      cyc++;
    end
    check("reach_byte10", 64'(byte_ptr >= 10), 64'd1);
    #2;
    mon_en = 1'b0;
    clear_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check_outputs_zero("midreset");
    @(posedge clk); #3;
    clear_n = 1'b1;
    fill_pattern(0);
    run_squeeze(32, 0, 0);
    check("post_reset_first", 64'(first_byte), 64'h00);
    check("post_reset_count", 64'(n_valid), 64'd32);
    check("post_reset_done_cnt", 64'(dut_done_cnt), 64'd1);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
